// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------+
// | mem_stage_pkg: shared widths and bus-FSM state encoding for the MEM   |
// | stage of the 16-bit pipeline.                        Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_bus_fsm.sv
// +----------------------------------------------------------------------+
// | mem_bus_fsm: req/ack access sequencer with timeout abort, stall and   |
// | sticky error flag.                                   Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_bus_fsm #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic ack_i,
  output logic access_o,
  output logic stall_o,
  output logic timeout_o,
  output logic err_o
);
  import mem_stage_pkg::*;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             access;
  logic             timeout;
  logic             stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The timeout cycle itself is not stalled: the aborted op retires on that edge.
  always_comb begin
    access  = (state_q == ACCESS);
    timeout = access & ~ack_i & (cnt_q == TO_VAL);
    stall   = access & ~ack_i & ~timeout;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | timeout;
    if (stall) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d   = '0;
      state_d = start_i ? ACCESS : IDLE;
    end
  end

  assign access_o  = access;
  assign stall_o   = stall;
  assign timeout_o = timeout;
  assign err_o     = err_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------+
// | mem_stage: EX/MEM register, bus access control, MEM-side forwarding   |
// | and MEM/WB register.                                 Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage #(
  parameter int DATA_W  = mem_stage_pkg::DATA_W,
  parameter int REG_W   = mem_stage_pkg::REG_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] alures_i,
  input  logic [DATA_W-1:0] storedata_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [REG_W-1:0]  regdst_i,
  input  logic              regwrite_i,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [REG_W-1:0]  memregdst_o,
  output logic              memregwrite_o,
  output logic [DATA_W-1:0] memregdata_o,
  output logic [REG_W-1:0]  wbregdst_o,
  output logic              wbregwrite_o,
  output logic [DATA_W-1:0] wbdata_o,
  output logic              err_o
);
  import mem_stage_pkg::*;

  logic              s_valid_q;
  logic              s_rd_q;
  logic              s_wr_q;
  logic [DATA_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [REG_W-1:0]  s_regdst_q;
  logic              s_regwrite_q;

  logic [REG_W-1:0]  wbregdst_q;
  logic              wbregwrite_q;
  logic [DATA_W-1:0] wbdata_q;

  logic              start;
  logic              access;
  logic              stall;
  logic              timeout;
  logic              fwd_write;
  logic [DATA_W-1:0] fwd_data;

  assign start = valid_i & (memread_i | memwrite_i);

  mem_bus_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .ack_i     (bus_ack_i),
    .access_o  (access),
    .stall_o   (stall),
    .timeout_o (timeout),
    .err_o     (err_o)
  );

  // A load only forwards in its ack cycle; a timed-out load therefore retires without a write.
  always_comb begin
    fwd_data  = s_rd_q ? bus_rdata_i : s_addr_q;
    fwd_write = s_valid_q & s_regwrite_q & (~s_rd_q | (access & bus_ack_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q    <= 1'b0;
      s_rd_q       <= 1'b0;
      s_wr_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_regdst_q   <= '0;
      s_regwrite_q <= 1'b0;
      wbregdst_q   <= '0;
      wbregwrite_q <= 1'b0;
      wbdata_q     <= '0;
    end else if (!stall) begin
      s_valid_q    <= valid_i;
      s_rd_q       <= memread_i & ~memwrite_i;
      s_wr_q       <= memwrite_i;
      s_addr_q     <= alures_i;
      s_wdata_q    <= storedata_i;
      s_regdst_q   <= regdst_i;
      s_regwrite_q <= regwrite_i;
      wbregdst_q   <= s_regdst_q;
      wbregwrite_q <= fwd_write;
      wbdata_q     <= fwd_data;
    end
  end

  assign stall_o       = stall;
  assign bus_req_o     = access;
  assign bus_we_o      = access & s_wr_q;
  assign bus_addr_o    = s_addr_q;
  assign bus_wdata_o   = s_wdata_q;
  assign memregdst_o   = s_regdst_q;
  assign memregwrite_o = fwd_write;
  assign memregdata_o  = fwd_data;
  assign wbregdst_o    = wbregdst_q;
  assign wbregwrite_o  = wbregwrite_q;
  assign wbdata_o      = wbdata_q;

  logic unused_timeout;
  assign unused_timeout = timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------+
// | tb_mem_stage: random instruction stream against a transaction-level   |
// | model of the MEM stage.                              Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  localparam int TO    = 4;
  localparam int NCYC  = 800;
  localparam int NEVER = 1000;

  typedef struct {
    logic        v;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdat;
    logic [3:0]  dst;
    logic        rw;
    int          delay;
    int          rstw;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, memread_i, memwrite_i, regwrite_i, bus_ack_i;
  logic [15:0] alures_i, storedata_i, bus_rdata_i;
  logic [3:0]  regdst_i;
  logic        stall_o, bus_req_o, bus_we_o, memregwrite_o, wbregwrite_o, err_o;
  logic [15:0] bus_addr_o, bus_wdata_o, memregdata_o, wbdata_o;
  logic [3:0]  memregdst_o, wbregdst_o;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(16), .REG_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alures_i(alures_i),
    .storedata_i(storedata_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .regdst_i(regdst_i), .regwrite_i(regwrite_i), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .memregdst_o(memregdst_o), .memregwrite_o(memregwrite_o),
    .memregdata_o(memregdata_o), .wbregdst_o(wbregdst_o),
    .wbregwrite_o(wbregwrite_o), .wbdata_o(wbdata_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic instr_t mk(logic v, logic rd, logic wr, logic [15:0] addr,
                                logic [15:0] wdata, logic [3:0] dst, logic rw,
                                int delay, int rstw, logic [15:0] rdat);
    instr_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
    t.dst = dst; t.rw = rw; t.delay = delay; t.rstw = rstw; t.rdat = rdat;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int     kind;
    kind    = $urandom_range(0, 7);
    t       = mk(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom),
                 1'($urandom), $urandom_range(0, 3), -1, 16'($urandom));
    if (kind == 0) t.v = 1'b0;
    if (kind == 4 || kind == 5) begin t.rd = 1'b1; t.rw = 1'b1; end
    if (kind == 6) begin t.wr = 1'b1; t.rw = 1'b0; end
    if (kind == 7) begin t.rd = 1'b1; t.wr = 1'b1; t.rw = 1'b0; end
    if ($urandom_range(0, 9) == 0) t.delay = NEVER;
    if ($urandom_range(0, 24) == 0) t.rstw = $urandom_range(0, 2);
    return t;
  endfunction

  // Model of the instruction currently held in MEM and of the MEM/WB result.
  logic        m_v, m_rd, m_wr, m_rw, m_err;
  logic [15:0] m_addr, m_wdata, m_rdat;
  logic [3:0]  m_dst;
  int          m_delay, m_rstw, m_wait;
  logic        wb_w;
  logic [3:0]  wb_dst;
  logic [15:0] wb_data;

  task automatic model_reset();
    m_v = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_rdat = 0; m_dst = 0;
    m_delay = 0; m_rstw = -1; m_wait = 0;
    wb_w = 0; wb_dst = 0; wb_data = 0;
  endtask

  instr_t dq[$];
  instr_t cur;
  logic   need_new;
  logic   pending, ack_e, to_e, stall_e, mw_e;
  logic [15:0] md_e;

  initial begin
    dq.push_back(mk(1, 0, 0, 16'h1234, 16'h0000, 4'd5, 1, 0, -1, 16'h0));
    dq.push_back(mk(1, 1, 0, 16'h0040, 16'h0000, 4'd3, 1, 2, -1, 16'hBEEF));
    dq.push_back(mk(1, 0, 1, 16'h00F0, 16'h0F00, 4'd0, 0, 0, -1, 16'h0));
    dq.push_back(mk(1, 1, 0, 16'h0100, 16'h0000, 4'd7, 1, 1, -1, 16'hCAFE));
    dq.push_back(mk(1, 0, 1, 16'h0102, 16'hA5A5, 4'd0, 0, 1, -1, 16'h0));
    dq.push_back(mk(1, 1, 0, 16'h0200, 16'h0000, 4'd9, 1, NEVER, -1, 16'h0));
    dq.push_back(mk(1, 1, 0, 16'h0300, 16'h0000, 4'd2, 1, NEVER, 1, 16'h0));
    dq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0, 0, -1, 16'h0));

    cur = mk(0, 0, 0, 16'h0, 16'h0, 4'd0, 0, 0, -1, 16'h0);
    rst = 1'b1; valid_i = 0; memread_i = 0; memwrite_i = 0; regwrite_i = 0;
    alures_i = 0; storedata_i = 0; regdst_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_req", bus_req_o, 0);
    check("rst_memregwrite", memregwrite_o, 0);
    check("rst_wbregwrite", wbregwrite_o, 0);
    check("rst_wbregdst", wbregdst_o, 0);
    check("rst_wbdata", wbdata_o, 0);
    check("rst_err", err_o, 0);
    model_reset();
    need_new = 1'b1;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (need_new) begin
        cur = (dq.size() > 0) ? dq.pop_front() : rand_instr();
        need_new = 1'b0;
      end
      valid_i = cur.v; memread_i = cur.rd; memwrite_i = cur.wr; alures_i = cur.addr;
      storedata_i = cur.wdata; regdst_i = cur.dst; regwrite_i = cur.rw;

      pending     = m_v && (m_rd || m_wr);
      ack_e       = pending && (m_wait == m_delay);
      to_e        = pending && !ack_e && (m_wait == TO);
      stall_e     = pending && !ack_e && !to_e;
      bus_ack_i   = ack_e ? 1'b1 : (!pending && ($urandom_range(0, 3) == 0));
      bus_rdata_i = ack_e ? m_rdat : 16'($urandom);
      rst         = (pending && (m_rstw == m_wait)) || ($urandom_range(0, 199) == 0);
      mw_e        = m_v && m_rw && (!m_rd || ack_e);
      md_e        = m_rd ? bus_rdata_i : m_addr;

      @(negedge clk);
      check("stall", stall_o, stall_e);
      check("bus_req", bus_req_o, pending);
      check("bus_we", bus_we_o, pending && m_wr);
      check("bus_addr", bus_addr_o, m_addr);
      check("bus_wdata", bus_wdata_o, m_wdata);
      check("memregdst", memregdst_o, m_dst);
      check("memregwrite", memregwrite_o, mw_e);
      check("memregdata", memregdata_o, md_e);
      check("wbregwrite", wbregwrite_o, wb_w);
      check("wbregdst", wbregdst_o, wb_dst);
      check("wbdata", wbdata_o, wb_data);
      check("err", err_o, m_err);

      if (rst) begin
        model_reset();
        cur.rstw = -1;
      end else if (!stall_e) begin
        wb_w = mw_e; wb_dst = m_dst; wb_data = md_e;
        if (to_e) m_err = 1'b1;
        m_v = cur.v; m_rd = cur.rd && !cur.wr; m_wr = cur.wr; m_addr = cur.addr;
        m_wdata = cur.wdata; m_dst = cur.dst; m_rw = cur.rw; m_rdat = cur.rdat;
        m_delay = cur.delay; m_rstw = cur.rstw; m_wait = 0;
        need_new = 1'b1;
      end else begin
        m_wait++;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
